// File: rtl/hs_ram_share.sv
// hs_ram_share: merges user pause with high-score RAM requests, grants the
// high-score engine the core's work-RAM port once the CPU has halted, and
// raises a screen-dim request after pause has been held for a set time.
module hs_ram_share #(
    parameter int unsigned AW         = 16,
    parameter int unsigned SETTLE     = 2,
    parameter logic [31:0] DIM_CYCLES = 32'h0BEBC200
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          pause_btn,
    input  logic          osd_open,
    input  logic          osd_pause_en,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_we,
    output logic          hs_gnt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_halted,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    output logic          pause,
    output logic          dim_video
);

    // cnt only ever holds SETTLE-1 down to 0
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HALT_REQ = 3'd1;
    localparam logic [2:0] ST_SETTLE   = 3'd2;
    localparam logic [2:0] ST_GRANT    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          tog;
    logic          btn_q;
    logic [31:0]   dcnt;

    // Previous button level; loads during reset so a held button does not toggle on exit
    always_ff @(posedge clk_sys) begin
        btn_q <= pause_btn;
    end

    // Handshake next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (hs_req) state_next = ST_HALT_REQ;
            end
            ST_HALT_REQ: begin
                if (!hs_req) begin
                    state_next = ST_IDLE;
                end else if (cpu_halted) begin
                    state_next = ST_SETTLE;
                    cnt_next   = CW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (!hs_req) begin
                    state_next = ST_IDLE;
                end else if (cnt == '0) begin
                    state_next = ST_GRANT;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_GRANT: begin
                if (!hs_req) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, settle counter, grant flag, pause toggle and dim counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hs_gnt <= 1'b0;
            tog    <= 1'b0;
            dcnt   <= 32'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            hs_gnt <= (state_next == ST_GRANT);
            if (pause_btn && !btn_q) tog <= ~tog;
            if (pause) begin
                if (dcnt < DIM_CYCLES) dcnt <= dcnt + 32'd1;
            end else begin
                dcnt <= 32'd0;
            end
        end
    end

    // Pause merge and dim flag
    assign pause     = (state != ST_IDLE) | tog | (osd_open & osd_pause_en);
    assign dim_video = (dcnt >= DIM_CYCLES);

    // RAM port mux; driven by the grant flop itself so hs_* never reach the RAM ungranted
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (hs_gnt) begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
            ram_we    = hs_we;
        end else if (state == ST_RELEASE) begin
            ram_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_ram_share.sv
// tb_hs_ram_share: directed + randomized stimulus against a behavioural model,
// expected outputs queued by the driver and compared by an independent monitor.
module tb_hs_ram_share;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned DIM    = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause_btn = 1'b0, osd_open = 1'b0, osd_pause_en = 1'b0;
    logic        hs_req = 1'b0, hs_we = 1'b0, cpu_we = 1'b0, cpu_halted = 1'b0;
    logic [15:0] hs_addr = 16'h0, cpu_addr = 16'h1234;
    logic [7:0]  hs_wdata = 8'h0, cpu_wdata = 8'h0;
    logic        hs_gnt, ram_we, pause, dim_video;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        reset, pause_btn, osd_open, osd_pause_en;
        logic        hs_req, hs_we, cpu_we, cpu_halted;
        logic [15:0] hs_addr, cpu_addr;
        logic [7:0]  hs_wdata, cpu_wdata;
    } stim_t;

    typedef struct {
        logic        pause, gnt, dim, we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t exp_q[$];

    hs_ram_share #(.AW(16), .SETTLE(SETTLE), .DIM_CYCLES(32'd10)) dut (
        .clk_sys(clk), .reset(reset), .pause_btn(pause_btn), .osd_open(osd_open),
        .osd_pause_en(osd_pause_en), .hs_req(hs_req), .hs_addr(hs_addr),
        .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_gnt(hs_gnt), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_halted(cpu_halted),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .pause(pause), .dim_video(dim_video)
    );

    always #5 clk = ~clk;

    // Reference model: handshake as "waiting for halt", "edges left to settle",
    // "granted", "releasing"; pause time as a saturating run length.
    bit m_wait = 0, m_gnt = 0, m_rel = 0, m_tog = 0, m_btn = 0;
    int m_left = 0, m_run = 0;

    function automatic bit m_busy();
        return m_wait || (m_left > 0) || m_gnt || m_rel;
    endfunction

    function automatic bit m_pause();
        return m_busy() || m_tog || (osd_open && osd_pause_en);
    endfunction

    always @(posedge clk) begin : model
        bit w, g, r, t;
        int sl, run;
        w = m_wait; g = m_gnt; r = m_rel; t = m_tog; sl = m_left; run = m_run;
        if (reset) begin
            w = 0; g = 0; r = 0; t = 0; sl = 0; run = 0;
        end else begin
            if (m_pause()) run = (run < DIM) ? run + 1 : run;
            else run = 0;
            if (pause_btn && !m_btn) t = !t;
            if (r) r = 0;
            else if (g) begin
                if (!hs_req) begin g = 0; r = 1; end
            end else if (sl > 0) begin
                if (!hs_req) sl = 0;
                else begin
                    sl = sl - 1;
                    if (sl == 0) g = 1;
                end
            end else if (w) begin
                if (!hs_req) w = 0;
                else if (cpu_halted) begin w = 0; sl = SETTLE; end
            end else if (hs_req) w = 1;
        end
        m_wait <= w; m_gnt <= g; m_rel <= r; m_tog <= t; m_left <= sl; m_run <= run;
        m_btn <= pause_btn;
    end

    // Drive one cycle of stimulus and queue the outputs the model predicts for it
    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.reset; pause_btn = s.pause_btn; osd_open = s.osd_open;
        osd_pause_en = s.osd_pause_en; hs_req = s.hs_req; hs_we = s.hs_we;
        cpu_we = s.cpu_we; cpu_halted = s.cpu_halted; hs_addr = s.hs_addr;
        cpu_addr = s.cpu_addr; hs_wdata = s.hs_wdata; cpu_wdata = s.cpu_wdata;
        #1;
        e.pause = m_pause();
        e.gnt   = m_gnt;
        e.dim   = (m_run >= DIM);
        e.addr  = m_gnt ? hs_addr : cpu_addr;
        e.wdata = m_gnt ? hs_wdata : cpu_wdata;
        e.we    = m_gnt ? hs_we : (m_rel ? 1'b0 : cpu_we);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pause",     16'(pause),     16'(e.pause));
                chk("hs_gnt",    16'(hs_gnt),    16'(e.gnt));
                chk("dim_video", 16'(dim_video), 16'(e.dim));
                chk("ram_we",    16'(ram_we),    16'(e.we));
                chk("ram_addr",  ram_addr,       e.addr);
                chk("ram_wdata", 16'(ram_wdata), 16'(e.wdata));
            end
        end
    end

    task automatic repeat_apply(input stim_t s, input int n);
        for (int i = 0; i < n; i++) apply(s);
    endtask

    initial begin : driver
        stim_t s;
        s = '{reset: 1'b1, pause_btn: 1'b0, osd_open: 1'b1, osd_pause_en: 1'b0,
              hs_req: 1'b0, hs_we: 1'b0, cpu_we: 1'b0, cpu_halted: 1'b0,
              hs_addr: 16'h0, cpu_addr: 16'h1234, hs_wdata: 8'h0, cpu_wdata: 8'h3C};
        // Reset state, OSD open without pause option
        repeat_apply(s, 3);
        s.reset = 1'b0;
        repeat_apply(s, 1);
        // Grant handshake
        s.hs_req = 1'b1;
        repeat_apply(s, 4);
        s.cpu_halted = 1'b1; s.hs_we = 1'b1; s.hs_addr = 16'h6100; s.hs_wdata = 8'hA5;
        repeat_apply(s, 5);
        // Release with CPU write pending
        s.hs_req = 1'b0; s.cpu_we = 1'b1;
        repeat_apply(s, 3);
        // Abort while waiting for halt
        s.cpu_halted = 1'b0; s.cpu_we = 1'b0; s.hs_req = 1'b1;
        repeat_apply(s, 1);
        s.hs_req = 1'b0;
        repeat_apply(s, 2);
        // User pause already holding the core
        s.pause_btn = 1'b1; s.cpu_halted = 1'b1;
        repeat_apply(s, 2);
        s.pause_btn = 1'b0; s.hs_req = 1'b1;
        repeat_apply(s, 6);
        s.hs_req = 1'b0;
        repeat_apply(s, 4);
        // Dim: release pause, then hold it past the dim threshold
        s.pause_btn = 1'b1; repeat_apply(s, 1);
        s.pause_btn = 1'b0; repeat_apply(s, 3);
        s.pause_btn = 1'b1; repeat_apply(s, 1);
        s.pause_btn = 1'b0; repeat_apply(s, 14);
        s.pause_btn = 1'b1; repeat_apply(s, 1);
        s.pause_btn = 1'b0; repeat_apply(s, 3);
        // Reset during grant
        s.hs_req = 1'b1; s.cpu_halted = 1'b1; s.hs_we = 1'b1;
        repeat_apply(s, 5);
        s.reset = 1'b1; repeat_apply(s, 1);
        s.reset = 1'b0; s.hs_req = 1'b0; repeat_apply(s, 2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)  s.hs_req       = ~s.hs_req;
            if ($urandom_range(3) == 0)  s.cpu_halted   = ~s.cpu_halted;
            if ($urandom_range(11) == 0) s.pause_btn    = ~s.pause_btn;
            if ($urandom_range(19) == 0) s.osd_open     = ~s.osd_open;
            if ($urandom_range(29) == 0) s.osd_pause_en = ~s.osd_pause_en;
            s.reset     = ($urandom_range(299) == 0);
            s.hs_we     = 1'($urandom);
            s.cpu_we    = 1'($urandom);
            s.hs_addr   = 16'($urandom);
            s.cpu_addr  = 16'($urandom);
            s.hs_wdata  = 8'($urandom);
            s.cpu_wdata = 8'($urandom);
            apply(s);
        end
        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hs_ram_share.md
# hs_ram_share

Pause and RAM-sharing controller placed between the arcade core, the high-score engine and the user pause inputs. Merges user pause (button toggle, OSD-open policy) with high-score access requests into the single `pause` sent to the core. Grants the high-score engine exclusive use of the core's work-RAM port only after the CPU acknowledges it has halted. Also produces the screen-dim flag once pause has been held for a programmed time.

## Interface
- `AW`, 16, RAM address width.
- `SETTLE`, 2, cycles between halt acknowledge and grant; must be ≥1.
- `DIM_CYCLES`, 32'h0BEBC200, pause duration before dimming (10 s at 20 MHz).

Ports:
- `clk_sys`  in  1  system clock; the block uses only this clock.
- `reset`  in  1  synchronous, active-high reset.
- `pause_btn`  in  1  user pause button, level, already in `clk_sys` domain.
- `osd_open`  in  1  OSD is visible.
- `osd_pause_en`  in  1  pause-on-OSD option enabled.
- `hs_req`  in  1  high-score engine requests RAM access (level).
- `hs_addr`  in  AW  high-score address.
- `hs_wdata`  in  8  high-score write data.
- `hs_we`  in  1  high-score write strobe; honoured only while granted.
- `hs_gnt`  out  1  RAM port owned by the high-score engine.
- `cpu_addr`  in  AW  core address.
- `cpu_wdata`  in  8  core write data.
- `cpu_we`  in  1  core write strobe.
- `cpu_halted`  in  1  core acknowledges pause (CPU stalled, bus idle).
- `ram_addr`  out  AW  muxed RAM address.
- `ram_wdata`  out  8  muxed RAM write data.
- `ram_we`  out  1  muxed RAM write enable.
- `pause`  out  1  pause to core.
- `dim_video`  out  1  dim request to the video path.

## Operation
- Pause toggle register `tog`:
  - A rising edge of `pause_btn` (registered previous value vs. current) inverts `tog`.
  - Cleared by `reset`.
- `pause = (state != IDLE) | tog | (osd_open & osd_pause_en)`. This is combinational from registered state and inputs.
- FSM states:
  - **IDLE**: `hs_req=1` → HALT_REQ.
  - **HALT_REQ**:
    - `hs_req=0` → IDLE.
    - Else `cpu_halted=1` → SETTLE, with `cnt=SETTLE-1`.
    - A core that is already halted by a user pause passes through HALT_REQ in one cycle.
  - **SETTLE**:
    - `hs_req=0` → IDLE.
    - Else `cnt==0` → GRANT; otherwise `cnt` decrements.
  - **GRANT**:
    - `hs_gnt=1`.
    - RAM mux selects the `hs_*` inputs.
    - `hs_req=0` → RELEASE.
    - `cpu_halted` is ignored in this state.
  - **RELEASE**:
    - `hs_gnt=0`.
    - Mux selects the CPU.
    - `ram_we` is forced 0.
    - `pause` is still asserted.
    - Moves to IDLE next cycle unconditionally. A new `hs_req` is served from IDLE.
- RAM mux outside GRANT: `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`, `ram_we=cpu_we`, except in RELEASE.
- Dim counter `dcnt` (32-bit):
  - While `pause=1`: increments, saturating at `DIM_CYCLES`.
  - While `pause=0`: set to 0 each cycle.
  - `dim_video = (dcnt >= DIM_CYCLES)`.
- Read data is not registered here. The RAM output feeds both requesters directly, and the high-score engine owns read latency.

## Timing
- Reset values: state IDLE, `tog=0`, `dcnt=0`, `cnt=0`, `hs_gnt=0`, `dim_video=0`.
  - `pause=osd_open&osd_pause_en`.
  - RAM outputs follow the CPU inputs.
- Reset mid-GRANT: on the reset edge `hs_gnt` falls and the mux returns to the CPU with no RELEASE cycle. `tog` clears.
- `pause` rises in the cycle after the edge that samples `hs_req=1` in IDLE.
- `hs_gnt` rises exactly `SETTLE` edges after the edge that samples `cpu_halted=1` in HALT_REQ.
- `hs_gnt` falls one edge after `hs_req=0` is sampled in GRANT. The `pause` contribution from the FSM drops one edge later.
- The grant mux change and `hs_gnt` change on the same edge. The mux is never driven from `hs_*` while `hs_gnt=0`.
- `pause_btn` edge and FSM transitions on the same edge are independent. If `tog` stays set, `pause` is held across RELEASE→IDLE.
- `dim_video` rises exactly `DIM_CYCLES` edges after `pause` first rises, provided `pause` is held continuously. It falls on the edge after `pause` falls.

## Test plan
- **Reset state**: reset 3 cycles, `osd_open=1`, `osd_pause_en=0` → `pause=0`, `hs_gnt=0`, `dim_video=0`; `ram_addr` tracks `cpu_addr=16'h1234`.
- **Grant handshake**, `SETTLE=2`:
  - `hs_req` high at edge 0 → `pause=1` from cycle 1.
  - `cpu_halted` high at edge 4 → `hs_gnt=1` after edge 6.
  - `hs_we=1`, `hs_addr=16'h6100`, `hs_wdata=8'hA5` → `ram_we=1`, `ram_addr=16'h6100`, `ram_wdata=8'hA5`.
- **Release**: drop `hs_req` in GRANT → `hs_gnt=0` next edge and `ram_we=0` during RELEASE (even with `cpu_we=1`); `pause=0` one edge later.
- **Abort / user pause**:
  - `hs_req` dropped while in HALT_REQ → IDLE, `hs_gnt` never rises.
  - With `tog=1` and `cpu_halted` already high, `pause` stays 1 throughout and after release.
- **Dim**: `DIM_CYCLES=10`, press `pause_btn` → `dim_video=1` 10 edges after `pause` rises; press again → `dim_video=0` the edge after `pause` falls.
- **Reset during GRANT** → `hs_gnt=0` and mux on the CPU at the reset edge; state IDLE; `tog=0`.
